iob_eth_tx_bd_sched: RTL and testbench
======================================

// Module: iob_eth_tx_bd_sched
// PURPOSE
//  TX buffer-descriptor scheduler for the iob_eth core. Walks TX BDs 0..tx_bd_num_i-1 in the BD RAM.
//  Polls each BD's READY bit, launches the TX DMA with the BD's pointer, length, PAD and CRC flags, and waits for DMA done.
//  Then writes status back, clears READY, raises interrupts and advances with wrap.
//  Sits between the CSR block (BD RAM port B, MODER.TXEN, TX_BD_NUM) and the TX DMA engine.
// PARAMETERS
//  BD_NUM_LOG2   7   log2 of total BDs; BD RAM holds 2 words per BD (word0 ctrl/status, word1 pointer)
//  PTR_W         32  DMA buffer pointer width
//  POLL_CYCLES   16  idle cycles between re-reads of a not-ready BD (>=1)
//  TIMEOUT_CYC   4096 DMA watchdog limit; used only with IOB_ETH_TX_SCHED_TIMEOUT_EN
// PORTS
//  clk_i        in   1              clock
//  cke_i        in   1              clock enable; all state frozen when 0
//  rst_i        in   1              synchronous active-high reset
//  tx_en_i      in   1              MODER.TXEN
//  tx_bd_num_i  in   BD_NUM_LOG2+1  number of TX BDs (0..2^BD_NUM_LOG2)
//  bd_en_o      out  1              BD RAM access strobe
//  bd_we_o      out  1              BD RAM write
//  bd_addr_o    out  BD_NUM_LOG2+1  BD RAM word address = {idx,word_sel}
//  bd_wdata_o   out  32             BD RAM write data
//  bd_rdata_i   in   32             BD RAM read data, valid 1 cycle after bd_en_o&!bd_we_o
//  dma_start_o  out  1              1-cycle pulse launching a frame
//  dma_ptr_o    out  PTR_W          frame buffer pointer (held until done)
//  dma_len_o    out  16             frame length in bytes (held)
//  dma_pad_o    out  1              pad enable (held)
//  dma_crc_o    out  1              CRC append enable (held)
//  dma_done_i   in   1              1-cycle pulse, frame finished
//  dma_status_i in   4              DMA status, valid with dma_done_i (0 = ok)
//  dma_abort_o  out  1              1-cycle abort pulse (only with TIMEOUT_EN, else tied 0)
//  txb_irq_o    out  1              1-cycle pulse: BD with IRQ set done with status 0
//  txe_irq_o    out  1              1-cycle pulse: BD with IRQ set done with status !=0
//  cur_bd_o     out  BD_NUM_LOG2    current TX BD index
//  busy_o       out  1              1 from LAUNCH through WRBACK
// BEHAVIOUR
//  BD word0: [31:16] LEN, [15] READY, [14] IRQ, [13] WR (wrap), [12] PAD, [11] CRC, [10:4] kept, [3:0] status.
//  Reset: state IDLE, idx 0, poll counter 0, every output 0.
//  FSM IDLE -> RD_CTRL -> RD_PTR -> LAUNCH -> WAIT_DONE -> WRBACK -> IDLE.
//  IDLE:
//   - With tx_en_i=1, tx_bd_num_i!=0 and poll counter 0: bd_en_o=1, addr={idx,0}; go RD_CTRL.
//   - Otherwise decrement the poll counter when it is non-zero.
//  RD_CTRL: latch word0.
//   - READY=0: load poll counter with POLL_CYCLES; go IDLE.
//   - READY=1, LEN!=0: read addr={idx,1}; go RD_PTR.
//   - READY=1, LEN==0: skip the DMA; go WRBACK with status 4'b1000.
//  RD_PTR: latch ptr; go LAUNCH.
//  LAUNCH: dma_start_o=1 for one cycle, with ptr/len/pad/crc driven the same cycle; go WAIT_DONE.
//   - Latency: dma_start_o is high 3 cycles after the IDLE read strobe.
//  WAIT_DONE: wait for dma_done_i; latch dma_status_i; go WRBACK.
//  WRBACK, exactly one cycle:
//   - bd_we_o=1, addr={idx,0}, wdata = latched word0 with READY=0 and [3:0]=status.
//   - If IRQ=1, pulse txb_irq_o when status==0, else txe_irq_o.
//   - idx <= 0 if WR=1 or idx==tx_bd_num_i-1, else idx+1. Go IDLE with poll counter 0, so the next BD is read immediately.
//  tx_en_i drop mid-frame: the current frame completes through WRBACK; no new read is issued.
//  tx_bd_num_i changes: sampled only at WRBACK wrap; idx>=tx_bd_num_i at IDLE forces idx=0 before the read.
//  dma_done_i outside WAIT_DONE is ignored. BD RAM writes and reads never occur in the same cycle.
//  rst_i mid-frame: immediate return to reset state; BD RAM is left unmodified.
// CONFIGURATION
//  IOB_ETH_TX_SCHED_TIMEOUT_EN defined:
//   - A 13-bit watchdog counts cycles in WAIT_DONE.
//   - At TIMEOUT_CYC without done: pulse dma_abort_o, go WRBACK with status 4'b0100.
//   - A dma_done_i arriving on the same cycle as the timeout wins.
//  Undefined: no watchdog; dma_abort_o tied 0; WAIT_DONE waits indefinitely.
// TESTING
//  1 BD0 = {LEN=0x0050,READY,IRQ,WR,PAD,CRC}, ptr 0x0, TXEN=1, tx_bd_num=1:
//    - dma_start_o 3 cycles after the read with len 0x50, ptr 0, pad=crc=1.
//    - Done with status 0 -> BD0 word0 = 0x0000_7800|0x0050<<16 with READY=0; txb_irq_o pulses; idx=0.
//  2 tx_bd_num=3, BD0..BD2 READY, no WR: three frames in order 0,1,2, then idx wraps to 0.
//    - BD2 done with status 4'h3 and IRQ=1 -> txe_irq_o pulses and word0[3:0]=3.
//  3 BD0 READY=0: read repeats every POLL_CYCLES+2 cycles with no dma_start_o.
//    - Set READY -> launch within POLL_CYCLES+4 cycles.
//  4 LEN=0 with READY: no dma_start_o; write-back status 4'b1000; idx advances.
//  5 rst_i asserted in WAIT_DONE: next cycle all outputs 0, idx 0; a later dma_done_i is ignored.
//  6 (TIMEOUT_EN) no dma_done_i: dma_abort_o pulses after 4096 WAIT_DONE cycles; status 4'b0100 written.

Source files
------------

// File: rtl/iob_eth_tx_bd_sched_if.sv
// BD RAM port and TX DMA handshake bundle for the iob_eth TX BD scheduler.
// master = scheduler side, slave = BD RAM / DMA side.
interface iob_eth_tx_bd_sched_if #(
  parameter int BD_NUM_LOG2 = 7,
  parameter int PTR_W       = 32
);
  logic                   bd_en_o;
  logic                   bd_we_o;
  logic [BD_NUM_LOG2:0]   bd_addr_o;
  logic [31:0]            bd_wdata_o;
  logic [31:0]            bd_rdata_i;
  logic                   dma_start_o;
  logic [PTR_W-1:0]       dma_ptr_o;
  logic [15:0]            dma_len_o;
  logic                   dma_pad_o;
  logic                   dma_crc_o;
  logic                   dma_done_i;
  logic [3:0]             dma_status_i;
  logic                   dma_abort_o;

  modport master (
    output bd_en_o, bd_we_o, bd_addr_o, bd_wdata_o,
    output dma_start_o, dma_ptr_o, dma_len_o, dma_pad_o, dma_crc_o, dma_abort_o,
    input  bd_rdata_i, dma_done_i, dma_status_i
  );

  modport slave (
    input  bd_en_o, bd_we_o, bd_addr_o, bd_wdata_o,
    input  dma_start_o, dma_ptr_o, dma_len_o, dma_pad_o, dma_crc_o, dma_abort_o,
    output bd_rdata_i, dma_done_i, dma_status_i
  );
endinterface

// File: rtl/iob_eth_tx_bd_sched.sv
// TX buffer-descriptor scheduler: polls TX BDs, launches the TX DMA, writes status back.
// Optional DMA watchdog enabled by defining IOB_ETH_TX_SCHED_TIMEOUT_EN.
//
// state       | meaning
// S_IDLE      | poll countdown; issues word0 read when enabled and countdown is 0
// S_RD_CTRL   | word0 on read data; decides poll / pointer read / zero-length skip
// S_RD_PTR    | word1 (buffer pointer) on read data
// S_LAUNCH    | dma_start_o pulse with pointer, length, pad, crc
// S_WAIT_DONE | waiting for dma_done_i (or watchdog expiry)
// S_WRBACK    | word0 write-back, interrupt pulse, index advance
module iob_eth_tx_bd_sched #(
  parameter int BD_NUM_LOG2 = 7,
  parameter int PTR_W       = 32,
  parameter int POLL_CYCLES = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk_i,
  input  logic                   cke_i,
  input  logic                   rst_i,
  input  logic                   tx_en_i,
  input  logic [BD_NUM_LOG2:0]   tx_bd_num_i,
  iob_eth_tx_bd_sched_if.master  bus,
  output logic                   txb_irq_o,
  output logic                   txe_irq_o,
  output logic [BD_NUM_LOG2-1:0] cur_bd_o,
  output logic                   busy_o
);
  localparam int PCW = $clog2(POLL_CYCLES + 1);
  localparam int NW  = BD_NUM_LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CTRL, S_RD_PTR, S_LAUNCH, S_WAIT_DONE, S_WRBACK
  } state_t;

  state_t                 state_q;
  logic [BD_NUM_LOG2-1:0] idx_q;
  logic [PCW-1:0]         poll_q;
  logic [31:4]            ctrl_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [3:0]             status_q;

  logic                   act;
  logic                   rd_go;
  logic                   rd_ptr;
  logic                   wrback;
  logic                   dma_act;
  logic [BD_NUM_LOG2-1:0] idx_eff;
  logic [BD_NUM_LOG2-1:0] idx_d;
  logic [NW-1:0]          addr_d;

  // Reset holds every strobe low so a frame cut short never writes the BD RAM.
  assign act     = cke_i & ~rst_i;
  assign idx_eff = ({1'b0, idx_q} >= tx_bd_num_i) ? '0 : idx_q;
  assign rd_go   = (state_q == S_IDLE) && tx_en_i && (tx_bd_num_i != '0) && (poll_q == '0);
  assign rd_ptr  = (state_q == S_RD_CTRL) && bus.bd_rdata_i[15] && (bus.bd_rdata_i[31:16] != 16'd0);
  assign wrback  = (state_q == S_WRBACK);
  assign dma_act = (state_q == S_LAUNCH) || (state_q == S_WAIT_DONE);
  assign idx_d   = (ctrl_q[13] || ({1'b0, idx_q} == tx_bd_num_i - NW'(1))) ? '0
                                                                          : idx_q + BD_NUM_LOG2'(1);

  always_comb begin
    addr_d = '0;
    if (rd_go)       addr_d = {idx_eff, 1'b0};
    else if (rd_ptr) addr_d = {idx_q, 1'b1};
    else if (wrback) addr_d = {idx_q, 1'b0};
  end

  assign bus.bd_en_o     = act & (rd_go | rd_ptr | wrback);
  assign bus.bd_we_o     = act & wrback;
  assign bus.bd_addr_o   = act ? addr_d : '0;
  assign bus.bd_wdata_o  = (act & wrback) ? {ctrl_q[31:16], 1'b0, ctrl_q[14:4], status_q} : '0;
  assign bus.dma_start_o = act & (state_q == S_LAUNCH);
  assign bus.dma_ptr_o   = dma_act ? ptr_q : '0;
  assign bus.dma_len_o   = dma_act ? ctrl_q[31:16] : '0;
  assign bus.dma_pad_o   = dma_act & ctrl_q[12];
  assign bus.dma_crc_o   = dma_act & ctrl_q[11];
  assign txb_irq_o       = act & wrback & ctrl_q[14] & (status_q == 4'd0);
  assign txe_irq_o       = act & wrback & ctrl_q[14] & (status_q != 4'd0);
  assign cur_bd_o        = idx_q;
  assign busy_o          = dma_act | wrback;

`ifdef IOB_ETH_TX_SCHED_TIMEOUT_EN
  logic [12:0] wdog_q;
  logic        abort_q;
  assign bus.dma_abort_o = act & abort_q;
`else
  assign bus.dma_abort_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      poll_q   <= '0;
      ctrl_q   <= '0;
      ptr_q    <= '0;
      status_q <= '0;
`ifdef IOB_ETH_TX_SCHED_TIMEOUT_EN
      wdog_q   <= '0;
      abort_q  <= 1'b0;
`endif
    end else if (cke_i) begin
`ifdef IOB_ETH_TX_SCHED_TIMEOUT_EN
      abort_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (rd_go) begin
            idx_q   <= idx_eff;
            state_q <= S_RD_CTRL;
          end else if (poll_q != '0) begin
            poll_q <= poll_q - PCW'(1);
          end
        end
        S_RD_CTRL: begin
          ctrl_q <= bus.bd_rdata_i[31:4];
          if (!bus.bd_rdata_i[15]) begin
            poll_q  <= PCW'(POLL_CYCLES);
            state_q <= S_IDLE;
          end else if (bus.bd_rdata_i[31:16] != 16'd0) begin
            state_q <= S_RD_PTR;
          end else begin
            status_q <= 4'b1000;
            state_q  <= S_WRBACK;
          end
        end
        S_RD_PTR: begin
          ptr_q   <= PTR_W'(bus.bd_rdata_i);
          state_q <= S_LAUNCH;
        end
        S_LAUNCH: begin
`ifdef IOB_ETH_TX_SCHED_TIMEOUT_EN
          wdog_q  <= '0;
`endif
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // A done arriving with the watchdog expiry takes precedence.
          if (bus.dma_done_i) begin
            status_q <= bus.dma_status_i;
            state_q  <= S_WRBACK;
          end
`ifdef IOB_ETH_TX_SCHED_TIMEOUT_EN
          else if (wdog_q == 13'(TIMEOUT_CYC - 1)) begin
            status_q <= 4'b0100;
            abort_q  <= 1'b1;
            state_q  <= S_WRBACK;
          end else begin
            wdog_q <= wdog_q + 13'd1;
          end
`endif
        end
        S_WRBACK: begin
          idx_q   <= idx_d;
          poll_q  <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iob_eth_tx_bd_sched.sv
// Directed bench for iob_eth_tx_bd_sched with a behavioural BD RAM and a hand-driven DMA.
// The watchdog scenario runs only when IOB_ETH_TX_SCHED_TIMEOUT_EN is defined.
module tb_iob_eth_tx_bd_sched;
  logic       clk = 1'b0;
  logic       cke = 1'b1;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic [7:0] tx_bd_num = 8'd0;
  logic       txb, txe, busy;
  logic [6:0] cur_bd;

  iob_eth_tx_bd_sched_if #(.BD_NUM_LOG2(7), .PTR_W(32)) bus ();

  iob_eth_tx_bd_sched #(.BD_NUM_LOG2(7), .PTR_W(32), .POLL_CYCLES(16), .TIMEOUT_CYC(4096)) dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .tx_en_i(tx_en), .tx_bd_num_i(tx_bd_num),
    .bus(bus), .txb_irq_o(txb), .txe_irq_o(txe), .cur_bd_o(cur_bd), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // BD RAM model, 1-cycle read latency; the bench preloads words through tb_wr.
  logic [31:0] mem [256];
  logic        tb_wr = 1'b0;
  logic [7:0]  tb_wa = 8'd0;
  logic [31:0] tb_wd = 32'd0;

  always @(posedge clk) begin
    if (tb_wr) mem[tb_wa] <= tb_wd;
    else if (bus.bd_en_o && bus.bd_we_o) mem[bus.bd_addr_o] <= bus.bd_wdata_o;
    if (bus.bd_en_o && !bus.bd_we_o) bus.bd_rdata_i <= mem[bus.bd_addr_o];
  end

  initial begin
    bus.dma_done_i   = 1'b0;
    bus.dma_status_i = 4'd0;
  end

  // Event monitor sampled on the falling edge.
  int          cyc = 0, rd_last = 0, rd_prev = 0, start_cyc = 0, abort_cyc = 0;
  int          start_cnt = 0, txb_cnt = 0, txe_cnt = 0, wb_cnt = 0, abort_cnt = 0;
  logic [31:0] st_ptr = 0;
  logic [15:0] st_len = 0;
  logic        st_pad = 0, st_crc = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.bd_en_o && !bus.bd_we_o && !bus.bd_addr_o[0]) begin
      rd_prev = rd_last;
      rd_last = cyc;
    end
    if (bus.dma_start_o) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
      st_ptr = bus.dma_ptr_o;
      st_len = bus.dma_len_o;
      st_pad = bus.dma_pad_o;
      st_crc = bus.dma_crc_o;
    end
    if (txb) txb_cnt = txb_cnt + 1;
    if (txe) txe_cnt = txe_cnt + 1;
    if (bus.bd_en_o && bus.bd_we_o) wb_cnt = wb_cnt + 1;
    if (bus.dma_abort_o) begin
      abort_cnt = abort_cnt + 1;
      abort_cyc = cyc;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mem_wr(input logic [7:0] a, input logic [31:0] d);
    tb_wa = a; tb_wd = d; tb_wr = 1'b1;
    @(posedge clk); #1;
    tb_wr = 1'b0;
  endtask

  task automatic pulse_done(input logic [3:0] st);
    bus.dma_done_i = 1'b1; bus.dma_status_i = st;
    @(posedge clk); #1;
    bus.dma_done_i = 1'b0; bus.dma_status_i = 4'd0;
  endtask

  task automatic wait_start(input int s0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (start_cnt != s0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; tx_en = 1'b0; tx_bd_num = 8'd0;
    tick(3);
    rst = 1'b0;
    tick(1);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_chk++; if (cur_bd !== 7'd0) begin n_fail++; $display("FAIL reset_cur_bd: got %0d expected 0", cur_bd); end
    n_chk++; if (bus.bd_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_bd_en: got %0b expected 0", bus.bd_en_o); end
    n_chk++; if (bus.dma_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %0b expected 0", bus.dma_start_o); end
    n_chk++; if (bus.dma_len_o !== 16'd0) begin n_fail++; $display("FAIL reset_len: got %0h expected 0", bus.dma_len_o); end
    n_chk++; if ({txb, txe} !== 2'b00) begin n_fail++; $display("FAIL reset_irq: got %0b expected 00", {txb, txe}); end
  endtask

  task automatic test_single;
    int s0, b0, e0;
    bit ok;
    mem_wr(8'd0, 32'h0050_F800);
    mem_wr(8'd1, 32'h0000_0000);
    tx_bd_num = 8'd1;
    s0 = start_cnt; b0 = txb_cnt; e0 = txe_cnt;
    tx_en = 1'b1;
    wait_start(s0, 30, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL single_start: got no start expected start"); end
    n_chk++; if (start_cyc - rd_last != 3) begin n_fail++; $display("FAIL single_latency: got %0d expected 3", start_cyc - rd_last); end
    n_chk++; if (st_len !== 16'h0050) begin n_fail++; $display("FAIL single_len: got %0h expected 50", st_len); end
    n_chk++; if (st_ptr !== 32'h0) begin n_fail++; $display("FAIL single_ptr: got %0h expected 0", st_ptr); end
    n_chk++; if ({st_pad, st_crc} !== 2'b11) begin n_fail++; $display("FAIL single_padcrc: got %0b expected 11", {st_pad, st_crc}); end
    tick(5);
    n_chk++; if (bus.dma_len_o !== 16'h0050 || busy !== 1'b1) begin n_fail++; $display("FAIL single_hold: got len %0h busy %0b expected 50 1", bus.dma_len_o, busy); end
    pulse_done(4'd0);
    tick(4);
    n_chk++; if (mem[0] !== 32'h0050_7800) begin n_fail++; $display("FAIL single_wb: got %08h expected 00507800", mem[0]); end
    n_chk++; if (txb_cnt - b0 != 1 || txe_cnt - e0 != 0) begin n_fail++; $display("FAIL single_irq: got txb %0d txe %0d expected 1 0", txb_cnt - b0, txe_cnt - e0); end
    n_chk++; if (cur_bd !== 7'd0) begin n_fail++; $display("FAIL single_idx: got %0d expected 0", cur_bd); end
    tx_en = 1'b0;
    tick(25);
  endtask

  task automatic test_multi;
    int s0, b0, e0;
    bit ok;
    logic [31:0] ptrs [3];
    ptrs[0] = 32'h1000; ptrs[1] = 32'h2000; ptrs[2] = 32'h3000;
    mem_wr(8'd0, 32'h0040_D800); mem_wr(8'd1, ptrs[0]);
    mem_wr(8'd2, 32'h0060_D800); mem_wr(8'd3, ptrs[1]);
    mem_wr(8'd4, 32'h0080_D800); mem_wr(8'd5, ptrs[2]);
    tx_bd_num = 8'd3;
    b0 = txb_cnt; e0 = txe_cnt;
    tx_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s0 = start_cnt;
      wait_start(s0, 40, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL multi_start%0d: got no start expected start", i); end
      n_chk++; if (st_ptr !== ptrs[i] || cur_bd !== 7'(i)) begin n_fail++; $display("FAIL multi_order%0d: got ptr %0h bd %0d expected %0h %0d", i, st_ptr, cur_bd, ptrs[i], i); end
      tick(2);
      pulse_done(i == 2 ? 4'h3 : 4'h0);
    end
    tick(4);
    n_chk++; if (cur_bd !== 7'd0) begin n_fail++; $display("FAIL multi_wrap: got %0d expected 0", cur_bd); end
    n_chk++; if (mem[0] !== 32'h0040_5800 || mem[2] !== 32'h0060_5800) begin n_fail++; $display("FAIL multi_wb01: got %08h %08h expected 00405800 00605800", mem[0], mem[2]); end
    n_chk++; if (mem[4] !== 32'h0080_5803) begin n_fail++; $display("FAIL multi_wb2: got %08h expected 00805803", mem[4]); end
    n_chk++; if (txb_cnt - b0 != 2 || txe_cnt - e0 != 1) begin n_fail++; $display("FAIL multi_irq: got txb %0d txe %0d expected 2 1", txb_cnt - b0, txe_cnt - e0); end
    tx_en = 1'b0;
    tick(25);
  endtask

  task automatic test_poll;
    int s0, b0, e0, set_cyc;
    bit ok;
    mem_wr(8'd0, 32'h0050_0000);
    mem_wr(8'd1, 32'h0000_4000);
    tx_bd_num = 8'd1;
    s0 = start_cnt; b0 = txb_cnt; e0 = txe_cnt;
    tx_en = 1'b1;
    tick(60);
    n_chk++; if (start_cnt != s0) begin n_fail++; $display("FAIL poll_nostart: got %0d starts expected 0", start_cnt - s0); end
    n_chk++; if (rd_last - rd_prev != 18) begin n_fail++; $display("FAIL poll_period: got %0d expected 18", rd_last - rd_prev); end
    mem_wr(8'd0, 32'h0050_A000);
    @(negedge clk); #1;
    set_cyc = cyc;
    wait_start(s0, 40, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL poll_start: got no start expected start"); end
    n_chk++; if (start_cyc - set_cyc > 20) begin n_fail++; $display("FAIL poll_launch_delay: got %0d expected <=20", start_cyc - set_cyc); end
    n_chk++; if (st_ptr !== 32'h4000) begin n_fail++; $display("FAIL poll_ptr: got %0h expected 4000", st_ptr); end
    pulse_done(4'd0);
    tick(4);
    n_chk++; if (mem[0] !== 32'h0050_2000) begin n_fail++; $display("FAIL poll_wb: got %08h expected 00502000", mem[0]); end
    n_chk++; if (txb_cnt != b0 || txe_cnt != e0) begin n_fail++; $display("FAIL poll_noirq: got txb %0d txe %0d expected 0 0", txb_cnt - b0, txe_cnt - e0); end
    tx_en = 1'b0;
    tick(25);
  endtask

  task automatic test_len0;
    int s0, e0;
    mem_wr(8'd0, 32'h0000_C000);
    mem_wr(8'd2, 32'h0000_0000);
    tx_bd_num = 8'd2;
    s0 = start_cnt; e0 = txe_cnt;
    tx_en = 1'b1;
    tick(30);
    n_chk++; if (start_cnt != s0) begin n_fail++; $display("FAIL len0_nostart: got %0d starts expected 0", start_cnt - s0); end
    n_chk++; if (mem[0] !== 32'h0000_4008) begin n_fail++; $display("FAIL len0_wb: got %08h expected 00004008", mem[0]); end
    n_chk++; if (cur_bd !== 7'd1) begin n_fail++; $display("FAIL len0_idx: got %0d expected 1", cur_bd); end
    n_chk++; if (txe_cnt - e0 != 1) begin n_fail++; $display("FAIL len0_irq: got %0d expected 1", txe_cnt - e0); end
    tx_en = 1'b0;
    tick(25);
  endtask

  task automatic test_reset_mid;
    int s0, w0, b0, e0;
    bit ok;
    mem_wr(8'd2, 32'h0020_9000);
    mem_wr(8'd3, 32'h0000_5000);
    s0 = start_cnt;
    tx_en = 1'b1;
    wait_start(s0, 40, ok);
    n_chk++; if (!ok || st_ptr !== 32'h5000 || cur_bd !== 7'd1) begin n_fail++; $display("FAIL rstmid_start: got ok %0b ptr %0h bd %0d expected 1 5000 1", ok, st_ptr, cur_bd); end
    tick(3);
    w0 = wb_cnt; b0 = txb_cnt; e0 = txe_cnt;
    rst = 1'b1; tx_en = 1'b0;
    tick(1);
    n_chk++; if (busy !== 1'b0 || cur_bd !== 7'd0) begin n_fail++; $display("FAIL rstmid_state: got busy %0b bd %0d expected 0 0", busy, cur_bd); end
    n_chk++; if (bus.dma_len_o !== 16'd0 || bus.dma_ptr_o !== 32'd0 || bus.bd_en_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_outs: got len %0h ptr %0h en %0b expected 0 0 0", bus.dma_len_o, bus.dma_ptr_o, bus.bd_en_o); end
    rst = 1'b0;
    tick(1);
    pulse_done(4'd0);
    tick(5);
    n_chk++; if (mem[2] !== 32'h0020_9000 || wb_cnt != w0) begin n_fail++; $display("FAIL rstmid_ram: got %08h writes %0d expected 00209000 0", mem[2], wb_cnt - w0); end
    n_chk++; if (txb_cnt != b0 || txe_cnt != e0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_done_ignored: got txb %0d txe %0d busy %0b expected 0 0 0", txb_cnt - b0, txe_cnt - e0, busy); end
  endtask

`ifdef IOB_ETH_TX_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    int s0, a0, e0;
    bit ok;
    mem_wr(8'd0, 32'h0010_C000);
    mem_wr(8'd1, 32'h0000_0100);
    tx_bd_num = 8'd1;
    s0 = start_cnt; a0 = abort_cnt; e0 = txe_cnt;
    tx_en = 1'b1;
    wait_start(s0, 40, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL tmo_start: got no start expected start"); end
    ok = 1'b0;
    for (int i = 0; i < 4200 && !ok; i++) begin
      @(posedge clk); #1;
      if (abort_cnt != a0) ok = 1'b1;
    end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL tmo_abort: got no abort expected abort"); end
    n_chk++; if (abort_cyc - start_cyc != 4097) begin n_fail++; $display("FAIL tmo_delay: got %0d expected 4097", abort_cyc - start_cyc); end
    tick(3);
    n_chk++; if (mem[0] !== 32'h0010_4004) begin n_fail++; $display("FAIL tmo_wb: got %08h expected 00104004", mem[0]); end
    n_chk++; if (txe_cnt - e0 != 1) begin n_fail++; $display("FAIL tmo_irq: got %0d expected 1", txe_cnt - e0); end
    tx_en = 1'b0;
    tick(5);
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_multi;
    test_poll;
    test_len0;
    test_reset_mid;
`ifdef IOB_ETH_TX_SCHED_TIMEOUT_EN
    test_timeout;
`else
    n_chk++; if (abort_cnt != 0) begin n_fail++; $display("FAIL no_abort: got %0d aborts expected 0", abort_cnt); end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
